// File: rtl/regfile_dump_reader.sv
// Streams a contiguous, optionally wrapping, range of register-file entries
// out over a valid/ready handshake, reading one index per word.
module regfile_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_idx,
    input  logic [ADDR_WIDTH-1:0] last_idx,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [ADDR_WIDTH-1:0] idx_r;
    logic [ADDR_WIDTH-1:0] end_idx_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [ADDR_WIDTH-1:0] out_index_r;
    logic                  out_last_r;
    logic                  out_valid_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  out_valid_next_s;
    logic                  busy_next_s;
    logic                  done_next_s;
    logic                  accept_s;

    assign accept_s = out_valid_r && out_ready;

    // State register; status flags are registered from the next-state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= out_valid_next_s;
            busy_r      <= busy_next_s;
            done_r      <= done_next_s;
        end
    end

    // Next-state decode; abort outranks a same-cycle handshake
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_FETCH;
                else       state_next_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (abort) state_next_s = ST_FINISH;
                else       state_next_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (abort)         state_next_s = ST_FINISH;
                else if (accept_s) state_next_s = out_last_r ? ST_FINISH : ST_FETCH;
                else               state_next_s = ST_HOLD;
            end
            ST_FINISH: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state, so the flags land in flops
    always_comb begin
        out_valid_next_s = 1'b0;
        busy_next_s      = 1'b0;
        done_next_s      = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                busy_next_s = 1'b0;
            end
            ST_FETCH: begin
                busy_next_s = 1'b1;
            end
            ST_HOLD: begin
                busy_next_s      = 1'b1;
                out_valid_next_s = 1'b1;
            end
            ST_FINISH: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Index walk and word capture; rf_data is sampled pre-edge, so a
    // same-edge core write to the register is not observed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= {ADDR_WIDTH{1'b0}};
            end_idx_r   <= {ADDR_WIDTH{1'b0}};
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_index_r <= {ADDR_WIDTH{1'b0}};
            out_last_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        idx_r     <= first_idx;
                        end_idx_r <= last_idx;
                    end
                end
                ST_FETCH: begin
                    if (!abort) begin
                        out_data_r  <= rf_data;
                        out_index_r <= idx_r;
                        out_last_r  <= (idx_r == end_idx_r);
                    end
                end
                ST_HOLD: begin
                    if (!abort && accept_s && !out_last_r) begin
                        idx_r <= idx_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    assign rf_addr   = idx_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_index = out_index_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: table of dump ranges plus
// hand-written sequences for collision, abort and mid-dump reset.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic        abort;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    int checks   = 0;
    int failures = 0;

    assign rf_data = regs[rf_addr];

    always #5 clk = ~clk;

    regfile_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_idx(first_idx),
        .last_idx(last_idx), .abort(abort), .rf_addr(rf_addr), .rf_data(rf_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    typedef struct {
        logic [4:0] f;
        logic [4:0] l;
        int         n;
        int         cyc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One dump; cycles counts negedges after the start edge up to the done pulse
    task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int exp_n,
                           input bit rnd, output int cycles);
        int          n;
        int          cyc;
        bit          got_done;
        bit          prev_stall;
        logic [31:0] pd;
        logic [4:0]  pi;
        logic [4:0]  ei;
        n = 0; cyc = 0; got_done = 1'b0; prev_stall = 1'b0; pd = 32'h0; pi = 5'd0;
        @(negedge clk);
        start = 1'b1; first_idx = f; last_idx = l; out_ready = 1'b1;
        while (!got_done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", out_data, pd);
                chk("stall_index", {27'd0, out_index}, {27'd0, pi});
            end
            if (done) begin
                got_done = 1'b1;
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                prev_stall = 1'b0;
                if (out_valid) begin
                    if (out_ready) begin
                        ei = f + 5'(n);
                        chk("word_index", {27'd0, out_index}, {27'd0, ei});
                        chk("word_data", out_data, regs[ei]);
                        chk("word_last", {31'd0, out_last}, {31'd0, (n == exp_n - 1)});
                        n++;
                    end else begin
                        prev_stall = 1'b1;
                        pd = out_data;
                        pi = out_index;
                    end
                end
            end
        end
        chk("done_seen", {31'd0, got_done}, 32'd1);
        chk("word_count", 32'(n), 32'(exp_n));
        cycles = cyc;
        out_ready = 1'b1;
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    vec_t vecs [6];
    int   cyc_got;
    int   wc;

    initial begin
        vecs[0] = '{f: 5'd0,  l: 5'd31, n: 32, cyc: 65};
        vecs[1] = '{f: 5'd30, l: 5'd1,  n: 4,  cyc: 9};
        vecs[2] = '{f: 5'd5,  l: 5'd5,  n: 1,  cyc: 3};
        vecs[3] = '{f: 5'd0,  l: 5'd0,  n: 1,  cyc: 3};
        vecs[4] = '{f: 5'd31, l: 5'd0,  n: 2,  cyc: 5};
        vecs[5] = '{f: 5'd10, l: 5'd3,  n: 26, cyc: 53};

        regs[0] = 32'h0;
        for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);

        rst_n = 1'b0; start = 1'b0; first_idx = 5'd0; last_idx = 5'd0;
        abort = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_addr", {27'd0, rf_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            do_dump(vecs[v].f, vecs[v].l, vecs[v].n, 1'b0, cyc_got);
            chk("dump_cycles", 32'(cyc_got), 32'(vecs[v].cyc));
        end

        do_dump(5'd3, 5'd10, 8, 1'b1, cyc_got);

        // Write collision: x7 updated on the same edge FETCH captures it
        regs[7] = 32'h0000_0007;
        @(negedge clk);
        start = 1'b1; first_idx = 5'd7; last_idx = 5'd7; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("coll_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        regs[7] <= 32'hDEAD_BEEF;
        @(negedge clk);
        chk("coll_valid", {31'd0, out_valid}, 32'd1);
        chk("coll_old_data", out_data, 32'h0000_0007);
        wc = 0;
        while (!done && wc < 10) begin
            @(negedge clk);
            wc++;
        end
        chk("coll_done", {31'd0, done}, 32'd1);
        do_dump(5'd7, 5'd7, 1, 1'b0, cyc_got);
        chk("coll_new_data", regs[7], 32'hDEAD_BEEF);

        // Abort while word 3 is held, with a stray start during the dump
        @(negedge clk);
        start = 1'b1; first_idx = 5'd0; last_idx = 5'd31; out_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 5) begin
                start = 1'b1;
                first_idx = 5'd20;
            end
        end
        chk("abort_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("abort_hold_index", {27'd0, out_index}, 32'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done", {31'd0, done}, 32'd1);
        chk("abort_valid_drop", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("abort_busy_low", {31'd0, busy}, 32'd0);
        chk("abort_done_low", {31'd0, done}, 32'd0);

        // Reset during HOLD of word 1
        @(negedge clk);
        start = 1'b1; first_idx = 5'd0; last_idx = 5'd31;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("prerst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_data", out_data, 32'd0);
        chk("midrst_index", {27'd0, out_index}, 32'd0);
        chk("midrst_addr", {27'd0, rf_addr}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        do_dump(5'd12, 5'd14, 3, 1'b0, cyc_got);
        chk("postrst_cycles", 32'(cyc_got), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
